// File: rtl/onehot_link_rx.sv
// Serial receiver for the 2-bit button-code link: synchronizes the line, checks the
// start/parity/stop framing and holds the decoded one-hot value until the next good frame.
module onehot_link_rx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       serial_in,
   output logic [3:0] out,
   output logic       frame_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            bit_idx_q, bit_idx_d;
   logic            d1_q, d1_d;
   logic            d0_q, d0_d;
   logic            par_q, par_d;
   logic [3:0]      out_q, out_d;
   logic            fv_q, fv_d;
   logic            fe_q, fe_d;
   logic            sync1_q, sync2_q;
   logic            rx;

   function automatic logic [3:0] decode(input logic [1:0] code);
      logic [3:0] onehot;
      case (code)
         2'b00:   onehot = 4'b1000;
         2'b01:   onehot = 4'b0100;
         2'b10:   onehot = 4'b0010;
         default: onehot = 4'b0001;
      endcase
      return onehot;
   endfunction

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= serial_in;
         sync2_q <= sync1_q;
      end
   end

   assign rx = sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 1'b0;
         d1_q      <= 1'b0;
         d0_q      <= 1'b0;
         par_q     <= 1'b0;
         out_q     <= 4'b0000;
         fv_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         d1_q      <= d1_d;
         d0_q      <= d0_d;
         par_q     <= par_d;
         out_q     <= out_d;
         fv_q      <= fv_d;
         fe_q      <= fe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      bit_idx_d = bit_idx_q;
      d1_d      = d1_q;
      d0_d      = d0_q;
      par_d     = par_q;
      out_d     = out_q;
      fv_d      = 1'b0;
      fe_d      = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx) state_d = START;
         end
         START: begin
            // Re-check the line at mid start bit so short low glitches are dropped.
            if (cnt_q == CNT_MID) begin
               cnt_d = '0;
               if (rx) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  bit_idx_d = 1'b0;
               end
            end
         end
         DATA: begin
            if (cnt_q == CNT_END) begin
               cnt_d = '0;
               if (!bit_idx_q) begin
                  d1_d      = rx;
                  bit_idx_d = 1'b1;
               end else begin
                  d0_d    = rx;
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (cnt_q == CNT_END) begin
               cnt_d   = '0;
               par_d   = rx;
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == CNT_END) begin
               cnt_d = '0;
               if (!rx) begin
                  fe_d    = 1'b1;
                  state_d = WAIT_IDLE;
               end else if (d1_q ^ d0_q ^ par_q) begin
                  out_d   = decode({d1_q, d0_q});
                  fv_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            cnt_d = '0;
            if (rx) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign out         = out_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;

endmodule

// File: tb/tb_onehot_link_rx.sv
// Directed bench for onehot_link_rx: framed codes, parity/stop errors, glitch and mid-frame reset.
module tb_onehot_link_rx;

   localparam int CPB = 4;

   logic       clk;
   logic       rst_n;
   logic       serial_in;
   logic [3:0] out;
   logic       frame_valid;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   // Free-running cycle count and pulse bookkeeping.
   int         cyc = 0;
   int         fv_cnt = 0;
   int         fe_cnt = 0;
   int         fv_cyc = 0;
   int         prev_fv_cyc = 0;
   logic [3:0] fv_out = 4'b0000;
   logic [3:0] prev_fv_out = 4'b0000;
   logic       fv_prev = 1'b0;
   logic       fe_prev = 1'b0;
   int         viol = 0;
   int         fall_cyc = 0;
   int         lat;

   onehot_link_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .serial_in   (serial_in),
      .out         (out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cnt      <= fv_cnt + 1;
         prev_fv_cyc <= fv_cyc;
         prev_fv_out <= fv_out;
         fv_cyc      <= cyc;
         fv_out      <= out;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if ((frame_valid && frame_err) || (frame_valid && fv_prev) || (frame_err && fe_prev))
         viol <= viol + 1;
      fv_prev <= frame_valid;
      fe_prev <= frame_err;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      serial_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // bits[4] = start ... bits[0] = stop, driven MSB first, each for CPB cycles.
   task automatic send_frame(input logic [4:0] bits);
      fall_cyc = cyc;
      for (int i = 4; i >= 0; i--) begin
         serial_in = bits[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   initial begin
      serial_in = 1'b1;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_out", 32'(out), 32'h0);
      chk("reset_fv", 32'(frame_valid), 32'h0);
      chk("reset_fe", 32'(frame_err), 32'h0);
      rst_n = 1'b1;
      idle(20);
      chk("idle_out", 32'(out), 32'h0);
      chk("idle_pulses", 32'(fv_cnt + fe_cnt), 32'h0);

      // Code 01 with good parity
      send_frame(5'b00101);
      idle(3);
      chk("c01_out", 32'(out), 32'h4);
      chk("c01_fv_cnt", 32'(fv_cnt), 32'd1);
      chk("c01_fe_cnt", 32'(fe_cnt), 32'd0);
      lat = fv_cyc - fall_cyc - 1;
      checks++;
      assert (lat >= 19 && lat <= 21)
      else begin
         errors++;
         $error("FAIL c01_latency observed=%0d expected=20+-1", lat);
      end

      // Back-to-back 11 then 10
      idle(4);
      send_frame(5'b01111);
      send_frame(5'b01001);
      idle(3);
      chk("b2b_fv_cnt", 32'(fv_cnt), 32'd3);
      chk("b2b_first_out", 32'(prev_fv_out), 32'h1);
      chk("b2b_second_out", 32'(fv_out), 32'h2);
      chk("b2b_spacing", 32'(fv_cyc - prev_fv_cyc), 32'd20);
      chk("b2b_out", 32'(out), 32'h2);

      // Parity error: code 00 with parity 0
      idle(4);
      send_frame(5'b00001);
      idle(3);
      chk("par_fe_cnt", 32'(fe_cnt), 32'd1);
      chk("par_fv_cnt", 32'(fv_cnt), 32'd3);
      chk("par_out", 32'(out), 32'h2);

      // Stop-bit error, line held low, then recovery with a good 00
      idle(4);
      send_frame(5'b00100);
      serial_in = 1'b0;
      repeat (10) @(negedge clk);
      chk("stop_fe_cnt", 32'(fe_cnt), 32'd2);
      chk("stop_fv_cnt", 32'(fv_cnt), 32'd3);
      chk("stop_out", 32'(out), 32'h2);
      idle(4);
      chk("stop_wait_pulses", 32'(fe_cnt + fv_cnt), 32'd5);
      send_frame(5'b00011);
      idle(3);
      chk("rec_out", 32'(out), 32'h8);
      chk("rec_fv_cnt", 32'(fv_cnt), 32'd4);
      chk("rec_fe_cnt", 32'(fe_cnt), 32'd2);

      // One-cycle low glitch
      idle(4);
      serial_in = 1'b0;
      @(negedge clk);
      idle(12);
      chk("glitch_pulses", 32'(fv_cnt + fe_cnt), 32'd6);
      chk("glitch_out", 32'(out), 32'h8);

      // Reset asserted in the d1 bit of an 11 frame
      serial_in = 1'b0;
      repeat (CPB) @(negedge clk);
      serial_in = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out", 32'(out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(24);
      chk("midrst_fv_cnt", 32'(fv_cnt), 32'd4);
      chk("midrst_fe_cnt", 32'(fe_cnt), 32'd2);
      chk("midrst_out_held", 32'(out), 32'h0);

      // Receiver still works after the reset
      send_frame(5'b01001);
      idle(3);
      chk("post_rst_out", 32'(out), 32'h2);
      chk("post_rst_fv_cnt", 32'(fv_cnt), 32'd5);

      chk("pulse_rules", 32'(viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/onehot_link_rx.md
Name: onehot_link_rx

Overview:
- Serial receiver for the 2-bit button-code link. The transmit side one-hot encodes 4 inputs to a 2-bit code and frames it onto a single wire.
- This block samples that wire, checks the frame and decodes the code back to a held 4-bit one-hot output.
- It is the far-end counterpart of the encoder/serializer path. It feeds the LED/output stage.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be even and >= 4.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- serial_in  input  1  link line; idles high; asynchronous to clk
- out  output  4  held one-hot decoded value
- frame_valid  output  1  one-cycle pulse when a good frame updates out
- frame_err  output  1  one-cycle pulse on parity or stop-bit error

Behaviour:
- Reset: one clock, reset is asynchronous and active-low (rst_n). On reset: out=4'b0000, frame_valid=0, frame_err=0, state=IDLE, synchronizer flops=1, counters=0.
- Frame format, line order: start(0), d1, d0 (MSB first), parity, stop(1). Each bit lasts CLKS_PER_BIT cycles. Parity is odd: d1^d0^parity must equal 1.
- serial_in passes through a 2-flop synchronizer (flops reset to 1). All logic uses the synced signal rx.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on rx==0, go to START and clear the cycle counter to 0.
- START: when the counter reaches CLKS_PER_BIT/2-1 (mid start bit), sample rx.
  - rx==1: glitch. Return to IDLE with no error pulse.
  - rx==0: go to DATA, counter=0, bit index=0.
- DATA: sample when the counter reaches CLKS_PER_BIT-1. First sample goes to d1, second to d0, then go to PARITY. The counter wraps to 0 after each sample.
- PARITY: sample at CLKS_PER_BIT-1, store the parity bit, go to STOP.
- STOP: sample at CLKS_PER_BIT-1.
  - Parity OK and rx==1: update out in the same edge, pulse frame_valid for 1 cycle, go to IDLE.
  - Parity bad and rx==1: pulse frame_err for 1 cycle, leave out unchanged, go to IDLE.
  - rx==0 (stop error, regardless of parity): pulse frame_err for 1 cycle, leave out unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx==1, then go to IDLE. No new frame is accepted while the line is held low.
- Decode map: code 00->1000, 01->0100, 10->0010, 11->0001. out holds its value until the next good frame. out is never 0000 except after reset.
- frame_valid and frame_err are mutually exclusive and never asserted for more than 1 cycle.
- Latency: with the first serial_in falling edge seen at cycle 0, frame_valid and the new out appear at cycle 2 (sync) + CLKS_PER_BIT/2 + 4*CLKS_PER_BIT, ±1 cycle of synchronizer phase.
- Back-to-back frames: a start bit immediately after a stop bit (no extra idle) must be received correctly. IDLE detects rx==0 on the cycle after the return from STOP.
- Reset asserted mid-frame: all state clears at once. After release, the partial frame is ignored until the line returns high and a new falling edge appears. If the line is low at release, IDLE treats it as a start. The resulting bad frame must end in frame_err or a glitch return, never frame_valid with stale data.
- serial_in changes are only sampled at mid-bit. Glitches shorter than CLKS_PER_BIT/2 inside a bit do not affect the result.

Test Plan:
- Reset, line idle high for 20 cycles -> out=0000, no pulses.
- Send code 01: bits 0,0,1,0,1 (CLKS_PER_BIT=4) -> out=0100, one frame_valid pulse at 2+2+16 cycles (±1) after the falling edge.
- Send 11 (0,1,1,1,1), then 10 (0,1,0,0,1) back-to-back with no idle between frames -> out=0001 then 0010, two frame_valid pulses 20 cycles apart.
- Send 00 with parity 0 (0,0,0,0,1) -> frame_err pulse, out keeps its previous value (0010).
- Send 01 with stop bit 0, hold line low 10 more cycles, then high, then a good 00 (0,0,0,1,1) -> frame_err pulse, no reception while low, then out=1000 with frame_valid.
- Pull serial_in low for 1 cycle only -> START sees rx==1 at mid-bit, returns to IDLE, no pulses, out unchanged. Then assert rst_n=0 mid-frame during a 11 frame -> out=0000 immediately, no frame_valid afterwards for that frame.
